// File: rtl/axi_dc_channel_reader_if.sv
// Registered valid/ready stream leaving the dual-clock channel reader.
// The reader drives data/valid; the downstream consumer drives ready.
interface axi_dc_channel_reader_if #(
  parameter int DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/axi_dc_channel_reader.sv
// Reader end of one dual-clock AXI channel slice.
// Synchronises writer tokens, drains slots in order, returns per-slot read toggles.
module axi_dc_channel_reader #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_WIDTH = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 isolate_i,
  input  logic [BUFFER_WIDTH*DATA_WIDTH-1:0]   async_data_i,
  input  logic [BUFFER_WIDTH-1:0]              async_writetoken_i,
  output logic [BUFFER_WIDTH-1:0]              async_readpointer_o,
  axi_dc_channel_reader_if.master              dst,
  output logic [$clog2(BUFFER_WIDTH):0]        fill_o
);
  localparam int FILL_W = $clog2(BUFFER_WIDTH) + 1;

  logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_WIDTH-1:0] wt_sync;
  logic [BUFFER_WIDTH-1:0] rd_tgl_q;
  logic [BUFFER_WIDTH-1:0] rd_idx_q;
  logic [BUFFER_WIDTH-1:0] full_vec;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [FILL_W-1:0]       fill;
  logic                    valid_q;
  logic                    head_full;
  logic                    load;

  // Plain flop chain only: any logic here would break the one-bit-per-cycle CDC property.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= async_writetoken_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign wt_sync   = sync_q[SYNC_STAGES-1];
  assign full_vec  = wt_sync ^ rd_tgl_q;
  assign head_full = |(full_vec & rd_idx_q);
  assign load      = head_full & ~isolate_i & (~valid_q | dst.ready);

  always_comb begin
    head_data = '0;
    fill      = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      if (rd_idx_q[i]) head_data = head_data | async_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      fill = fill + FILL_W'(full_vec[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_tgl_q <= '0;
      rd_idx_q <= BUFFER_WIDTH'(1);
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else if (load) begin
      data_q   <= head_data;
      valid_q  <= 1'b1;
      rd_tgl_q <= rd_tgl_q ^ rd_idx_q;
      rd_idx_q <= {rd_idx_q[BUFFER_WIDTH-2:0], rd_idx_q[BUFFER_WIDTH-1]};
    end else if (valid_q && dst.ready && !isolate_i) begin
      // Isolation keeps the held beat so it can be re-presented afterwards.
      valid_q <= 1'b0;
    end
  end

  assign async_readpointer_o = rd_tgl_q;
  assign dst.data            = data_q;
  assign dst.valid           = valid_q & ~isolate_i;
  assign fill_o              = fill;
endmodule

// File: tb/tb_axi_dc_channel_reader.sv
// Directed bench for the channel reader: the bench plays the writer end and
// checks each scenario against hand-computed beats, fill levels and read toggles.
module tb_axi_dc_channel_reader;
  localparam int DW = 8;
  localparam int BW = 8;
  localparam int SS = 2;

  logic          clk;
  logic          rst_ni;
  logic          isolate;
  logic [BW*DW-1:0] async_data;
  logic [BW-1:0] wtok;
  logic [BW-1:0] rptr;
  logic [$clog2(BW):0] fill;

  int passed;
  int total;

  axi_dc_channel_reader_if #(.DATA_WIDTH(DW)) bus ();

  axi_dc_channel_reader #(
    .DATA_WIDTH(DW), .BUFFER_WIDTH(BW), .SYNC_STAGES(SS)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .isolate_i(isolate),
    .async_data_i(async_data),
    .async_writetoken_i(wtok),
    .async_readpointer_o(rptr),
    .dst(bus),
    .fill_o(fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int i, input logic [DW-1:0] d);
    async_data[i*DW +: DW] = d;
    wtok[i] = ~wtok[i];
  endtask

  task automatic do_reset();
    step();
    rst_ni = 1'b0; wtok = '0; async_data = '0; bus.ready = 1'b0; isolate = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.valid); else passed++;
    total++; if (rptr !== 8'h00) $display("FAIL reset_rptr got=%h exp=00", rptr); else passed++;
    total++; if (fill !== 4'd0) $display("FAIL reset_fill got=%0d exp=0", fill); else passed++;
    total++; if (bus.data !== 8'h00) $display("FAIL reset_data got=%h exp=00", bus.data); else passed++;
  endtask

  task automatic test_single_beat();
    step();
    write_slot(0, 8'hA5);
    bus.ready = 1'b1;
    step();
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b0) $display("FAIL single_early_valid got=%b exp=0", bus.valid); else passed++;
    total++; if (fill !== 4'd1) $display("FAIL single_fill got=%0d exp=1", fill); else passed++;
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", bus.valid); else passed++;
    total++; if (bus.data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", bus.data); else passed++;
    total++; if (rptr !== 8'h01) $display("FAIL single_rptr got=%h exp=01", rptr); else passed++;
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b0) $display("FAIL single_one_beat got=%b exp=0", bus.valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_rptr;
    do_reset();
    step();
    for (int i = 0; i < BW; i++) write_slot(i, 8'h10 + 8'(i));
    bus.ready = 1'b1;
    step();
    step();
    @(negedge clk);
    total++; if (fill !== 4'd8) $display("FAIL b2b_fill_peak got=%0d exp=8", fill); else passed++;
    exp_rptr = 8'h00;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 1) write_slot(0, 8'h18);
      exp_rptr[k % BW] = ~exp_rptr[k % BW];
      @(negedge clk);
      total++; if (bus.valid !== 1'b1) $display("FAIL b2b_valid beat=%0d got=%b exp=1", k, bus.valid); else passed++;
      total++; if (bus.data !== 8'h10 + 8'(k)) $display("FAIL b2b_data beat=%0d got=%h exp=%h", k, bus.data, 8'h10 + 8'(k)); else passed++;
      total++; if (rptr !== exp_rptr) $display("FAIL b2b_rptr beat=%0d got=%h exp=%h", k, rptr, exp_rptr); else passed++;
    end
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b0) $display("FAIL b2b_drained got=%b exp=0", bus.valid); else passed++;
    total++; if (fill !== 4'd0) $display("FAIL b2b_fill_empty got=%0d exp=0", fill); else passed++;
  endtask

  task automatic test_backpressure();
    step();
    write_slot(1, 8'h21); write_slot(2, 8'h22); write_slot(3, 8'h23);
    bus.ready = 1'b0;
    step();
    step();
    for (int j = 0; j < 5; j++) begin
      step();
      @(negedge clk);
      total++; if (bus.valid !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", j, bus.valid); else passed++;
      total++; if (bus.data !== 8'h21) $display("FAIL bp_data cyc=%0d got=%h exp=21", j, bus.data); else passed++;
      total++; if (fill !== 4'd2) $display("FAIL bp_fill cyc=%0d got=%0d exp=2", j, fill); else passed++;
      total++; if (rptr !== 8'hFC) $display("FAIL bp_rptr cyc=%0d got=%h exp=fc", j, rptr); else passed++;
    end
    step();
    bus.ready = 1'b1;
    @(negedge clk);
    total++; if (bus.data !== 8'h21) $display("FAIL bp_hold got=%h exp=21", bus.data); else passed++;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      total++; if (bus.valid !== 1'b1 || bus.data !== 8'h22 + 8'(k))
        $display("FAIL bp_drain beat=%0d got=%b/%h exp=1/%h", k, bus.valid, bus.data, 8'h22 + 8'(k)); else passed++;
    end
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b0) $display("FAIL bp_end_valid got=%b exp=0", bus.valid); else passed++;
    total++; if (rptr !== 8'hF0) $display("FAIL bp_end_rptr got=%h exp=f0", rptr); else passed++;
  endtask

  task automatic test_isolate();
    step();
    write_slot(4, 8'h31); write_slot(5, 8'h32); write_slot(6, 8'h33);
    bus.ready = 1'b0;
    step();
    step();
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b1 || bus.data !== 8'h31)
      $display("FAIL iso_pre got=%b/%h exp=1/31", bus.valid, bus.data); else passed++;
    step();
    isolate = 1'b1;
    bus.ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      total++; if (bus.valid !== 1'b0) $display("FAIL iso_valid cyc=%0d got=%b exp=0", j, bus.valid); else passed++;
      total++; if (rptr !== 8'hE0) $display("FAIL iso_rptr cyc=%0d got=%h exp=e0", j, rptr); else passed++;
      total++; if (fill !== 4'd2) $display("FAIL iso_fill cyc=%0d got=%0d exp=2", j, fill); else passed++;
      step();
    end
    isolate = 1'b0;
    @(negedge clk);
    total++; if (bus.valid !== 1'b1 || bus.data !== 8'h31)
      $display("FAIL iso_represent got=%b/%h exp=1/31", bus.valid, bus.data); else passed++;
    for (int k = 0; k < 2; k++) begin
      step();
      @(negedge clk);
      total++; if (bus.valid !== 1'b1 || bus.data !== 8'h32 + 8'(k))
        $display("FAIL iso_drain beat=%0d got=%b/%h exp=1/%h", k, bus.valid, bus.data, 8'h32 + 8'(k)); else passed++;
    end
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b0) $display("FAIL iso_end_valid got=%b exp=0", bus.valid); else passed++;
    total++; if (rptr !== 8'h80) $display("FAIL iso_end_rptr got=%h exp=80", rptr); else passed++;
  endtask

  task automatic test_reset_midstream();
    step();
    write_slot(7, 8'h41); write_slot(0, 8'h42); write_slot(1, 8'h43);
    write_slot(2, 8'h44); write_slot(3, 8'h45); write_slot(4, 8'h46);
    bus.ready = 1'b1;
    step();
    step();
    step();
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b1 || bus.data !== 8'h42)
      $display("FAIL mid_pre got=%b/%h exp=1/42", bus.valid, bus.data); else passed++;
    total++; if (fill !== 4'd4) $display("FAIL mid_pre_fill got=%0d exp=4", fill); else passed++;
    total++; if (rptr !== 8'h01) $display("FAIL mid_pre_rptr got=%h exp=01", rptr); else passed++;
    rst_ni = 1'b0;
    wtok = '0;
    async_data = '0;
    @(negedge clk);
    total++; if (bus.valid !== 1'b0) $display("FAIL mid_rst_valid got=%b exp=0", bus.valid); else passed++;
    total++; if (rptr !== 8'h00) $display("FAIL mid_rst_rptr got=%h exp=00", rptr); else passed++;
    total++; if (fill !== 4'd0) $display("FAIL mid_rst_fill got=%0d exp=0", fill); else passed++;
    total++; if (bus.data !== 8'h00) $display("FAIL mid_rst_data got=%h exp=00", bus.data); else passed++;
    step();
    rst_ni = 1'b1;
    step();
    write_slot(0, 8'h55);
    step();
    step();
    step();
    @(negedge clk);
    total++; if (bus.valid !== 1'b1 || bus.data !== 8'h55)
      $display("FAIL mid_restart got=%b/%h exp=1/55", bus.valid, bus.data); else passed++;
    total++; if (rptr !== 8'h01) $display("FAIL mid_restart_rptr got=%h exp=01", rptr); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst_ni = 1'b0;
    isolate = 1'b0;
    async_data = '0;
    wtok = '0;
    bus.ready = 1'b0;
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_isolate();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
